alu_ctrl_stage: RTL

- Registered ID/EX control stage of the pipelined MIPS core.
- Decodes the instruction into the control encoding the ALU consumes: unit select, 3-bit logic opsel and subtract flag.
- Selects and extends operands, then registers everything for the execute stage.
- Supports pipeline stall (hold) and flush (bubble) with one-cycle latency.

---
 rtl/alu_ctrl_stage_if.sv | 37 +++
 rtl/alu_ctrl_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_stage_if.sv
// ID/EX handshake bundle: decode-side inputs, stall/flush controls
// and the registered EX control outputs.
// Ports: id_valid/id_instr/id_rs_val/id_rt_val, ex_stall/ex_flush in;
// ex_valid/unit/log_opsel/arith_sub/op_a/op_b/dest/wr_en/illegal out.
interface alu_ctrl_stage_if #(
   parameter int REG_WIDTH = 32
);
   logic                 id_valid;
   logic [31:0]          id_instr;
   logic [REG_WIDTH-1:0] id_rs_val;
   logic [REG_WIDTH-1:0] id_rt_val;
   logic                 ex_stall;
   logic                 ex_flush;
   logic                 ex_valid;
   logic                 ex_unit;
   logic [2:0]           ex_log_opsel;
   logic                 ex_arith_sub;
   logic [REG_WIDTH-1:0] ex_op_a;
   logic [REG_WIDTH-1:0] ex_op_b;
   logic [4:0]           ex_dest;
   logic                 ex_wr_en;
   logic                 ex_illegal;

   modport master (
      output id_valid, id_instr, id_rs_val, id_rt_val,
      output ex_stall, ex_flush,
      input  ex_valid, ex_unit, ex_log_opsel, ex_arith_sub,
      input  ex_op_a, ex_op_b, ex_dest, ex_wr_en, ex_illegal
   );

   modport slave (
      input  id_valid, id_instr, id_rs_val, id_rt_val,
      input  ex_stall, ex_flush,
      output ex_valid, ex_unit, ex_log_opsel, ex_arith_sub,
      output ex_op_a, ex_op_b, ex_dest, ex_wr_en, ex_illegal
   );
endinterface

// File: rtl/alu_ctrl_stage.sv
// Registered ID/EX control stage: decodes MIPS ALU ops into unit/opsel/sub,
// picks operands and registers them. Ports: clk, rst_n, bus (slave).
module alu_ctrl_stage #(
   parameter int REG_WIDTH = 32
) (
   input logic            clk,
   input logic            rst_n,
   alu_ctrl_stage_if.slave bus
);

   typedef struct packed {
      logic                 valid;
      logic                 unit;
      logic [2:0]           opsel;
      logic                 sub;
      logic [REG_WIDTH-1:0] op_a;
      logic [REG_WIDTH-1:0] op_b;
      logic [4:0]           dest;
      logic                 wr_en;
      logic                 illegal;
   } ex_t;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm;

   assign op    = bus.id_instr[31:26];
   assign rt    = bus.id_instr[20:16];
   assign rd    = bus.id_instr[15:11];
   assign imm   = bus.id_instr[15:0];
   assign funct = bus.id_instr[5:0];

   // rs arrives already read as id_rs_val
   logic unused_rs;
   assign unused_rs = ^bus.id_instr[25:21];

   logic [REG_WIDTH-1:0] imm_sext;
   logic [REG_WIDTH-1:0] imm_zext;

   generate
      if (REG_WIDTH > 16) begin : g_ext
         assign imm_sext = {{(REG_WIDTH-16){imm[15]}}, imm};
         assign imm_zext = {{(REG_WIDTH-16){1'b0}}, imm};
      end else if (REG_WIDTH == 16) begin : g_same
         assign imm_sext = imm;
         assign imm_zext = imm;
      end else begin : g_trunc
         logic unused_imm_hi;
         assign unused_imm_hi = ^imm[15:REG_WIDTH];
         assign imm_sext = imm[REG_WIDTH-1:0];
         assign imm_zext = imm[REG_WIDTH-1:0];
      end
   endgenerate

   logic                 d_ok;
   logic                 d_unit;
   logic [2:0]           d_opsel;
   logic                 d_sub;
   logic [REG_WIDTH-1:0] d_b;
   logic [4:0]           d_dest;

   always_comb begin
      d_ok    = 1'b0;
      d_unit  = 1'b0;
      d_opsel = 3'b000;
      d_sub   = 1'b0;
      d_b     = '0;
      d_dest  = '0;
      unique case (op)
         6'h00: begin
            d_ok   = 1'b1;
            d_b    = bus.id_rt_val;
            d_dest = rd;
            unique case (funct)
               6'h20, 6'h21: d_unit = 1'b1;
               6'h22, 6'h23: begin
                  d_unit = 1'b1;
                  d_sub  = 1'b1;
               end
               6'h24: d_opsel = 3'b000;
               6'h25: d_opsel = 3'b001;
               6'h26: d_opsel = 3'b011;
               6'h27: d_opsel = 3'b010;
               6'h2A: d_opsel = 3'b100;
               default: d_ok = 1'b0;
            endcase
         end
         6'h08, 6'h09: begin
            d_ok   = 1'b1;
            d_unit = 1'b1;
            d_b    = imm_sext;
            d_dest = rt;
         end
         6'h0A: begin
            d_ok    = 1'b1;
            d_opsel = 3'b100;
            d_b     = imm_sext;
            d_dest  = rt;
         end
         6'h0C, 6'h0D, 6'h0E: begin
            d_ok    = 1'b1;
            d_opsel = (op == 6'h0C) ? 3'b000 :
                      (op == 6'h0D) ? 3'b001 : 3'b011;
            d_b     = imm_zext;
            d_dest  = rt;
         end
         default: d_ok = 1'b0;
      endcase
   end

   ex_t ex_d;
   ex_t ex_q;

   // Bubble when empty; unsupported op becomes a bubble tagged illegal
   always_comb begin
      ex_d = '0;
      if (bus.id_valid) begin
         if (d_ok) begin
            ex_d.valid = 1'b1;
            ex_d.unit  = d_unit;
            ex_d.opsel = d_opsel;
            ex_d.sub   = d_sub;
            ex_d.op_a  = bus.id_rs_val;
            ex_d.op_b  = d_b;
            ex_d.dest  = d_dest;
            ex_d.wr_en = (d_dest != 5'd0);
         end else begin
            ex_d.illegal = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q <= '0;
      end else if (bus.ex_flush) begin
         ex_q <= '0;
      end else if (!bus.ex_stall) begin
         ex_q <= ex_d;
      end
   end

   assign bus.ex_valid     = ex_q.valid;
   assign bus.ex_unit      = ex_q.unit;
   assign bus.ex_log_opsel = ex_q.opsel;
   assign bus.ex_arith_sub = ex_q.sub;
   assign bus.ex_op_a      = ex_q.op_a;
   assign bus.ex_op_b      = ex_q.op_b;
   assign bus.ex_dest      = ex_q.dest;
   assign bus.ex_wr_en     = ex_q.wr_en;
   assign bus.ex_illegal   = ex_q.illegal;

endmodule
